pipelined_register_file: RTL and testbench

Parametrised general-purpose register file for the pipelined MIPS datapath: two combinational read ports, one write port, same-cycle write-to-read bypass, and a per-register pending scoreboard. The decode stage reads operands and asks whether they are still in flight. The issue stage marks destinations pending. Writeback both writes data and clears the pending flag.

---
 rtl/pipelined_register_file.sv | 88 ++++++++
 tb/tb_pipelined_register_file.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_register_file.sv
// General-purpose register file with two combinational read ports, one write port,
// same-cycle write-to-read bypass and a per-register pending scoreboard.
module pipelined_register_file #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [AW-1:0]    RA,
    input  logic [AW-1:0]    RB,
    input  logic [AW-1:0]    RW,
    input  logic [WIDTH-1:0] BusW,
    input  logic             RegWr,
    input  logic [AW-1:0]    IssueDst,
    input  logic             IssueValid,
    output logic [WIDTH-1:0] BusA,
    output logic [WIDTH-1:0] BusB,
    output logic             HazA,
    output logic             HazB,
    output logic [AW:0]      PendCount
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_next;
    logic             do_write;
    logic             do_issue;
    logic             cnt_inc;
    logic             cnt_dec;

    function automatic logic writable(input logic [AW-1:0] addr);
        return (ZERO_REG == 0) || (addr != '0);
    endfunction

    assign do_write = RegWr && writable(RW);
    assign do_issue = IssueValid && writable(IssueDst);

    // Issue is applied after writeback so a same-register collision leaves the flag set.
    always_comb begin
        pend_next = pend;
        if (do_write) pend_next[RW] = 1'b0;
        if (do_issue) pend_next[IssueDst] = 1'b1;
    end

    assign cnt_inc = do_issue && !pend[IssueDst];
    assign cnt_dec = do_write && pend[RW] && !(do_issue && (IssueDst == RW));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            pend      <= '0;
            PendCount <= '0;
        end else begin
            if (do_write) begin
                mem[RW] <= BusW;
            end
            pend      <= pend_next;
            PendCount <= PendCount + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
        end
    end

    always_comb begin
        BusA = mem[RA];
        if (!writable(RA)) begin
            BusA = '0;
        end else if (RegWr && (RW == RA)) begin
            BusA = BusW;
        end
    end

    always_comb begin
        BusB = mem[RB];
        if (!writable(RB)) begin
            BusB = '0;
        end else if (RegWr && (RW == RB)) begin
            BusB = BusW;
        end
    end

    // A writeback landing this cycle resolves the hazard for the reader.
    assign HazA = pend[RA] & ~(RegWr & (RW == RA) & writable(RA));
    assign HazB = pend[RB] & ~(RegWr & (RW == RB) & writable(RB));

endmodule

// File: tb/tb_pipelined_register_file.sv
// Bench for pipelined_register_file: directed vector table on the 32x32 zero-register
// instance, hand sequences and a model-checked random run on a 16x8 instance.
module tb_pipelined_register_file;

    typedef struct {
        bit          sel;
        bit          rst;
        bit          regwr;
        logic [4:0]  rw;
        logic [31:0] busw;
        bit          iv;
        logic [4:0]  dst;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        bit          exp_ha;
        bit          exp_hb;
        int          exp_pc;
        int          tag;
    } vec_t;

    logic        Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        rst32, regwr32, iv32;
    logic [4:0]  ra32, rb32, rw32, dst32;
    logic [31:0] busw32, bus_a32, bus_b32;
    logic        haz_a32, haz_b32;
    logic [5:0]  pc32;

    logic        rst16, regwr16, iv16;
    logic [2:0]  ra16, rb16, rw16, dst16;
    logic [15:0] busw16, bus_a16, bus_b16;
    logic        haz_a16, haz_b16;
    logic [3:0]  pc16;

    pipelined_register_file dut32 (
        .Clk(Clk), .Reset(rst32), .RA(ra32), .RB(rb32), .RW(rw32), .BusW(busw32),
        .RegWr(regwr32), .IssueDst(dst32), .IssueValid(iv32),
        .BusA(bus_a32), .BusB(bus_b32), .HazA(haz_a32), .HazB(haz_b32), .PendCount(pc32)
    );

    pipelined_register_file #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0)) dut16 (
        .Clk(Clk), .Reset(rst16), .RA(ra16), .RB(rb16), .RW(rw16), .BusW(busw16),
        .RegWr(regwr16), .IssueDst(dst16), .IssueValid(iv16),
        .BusA(bus_a16), .BusB(bus_b16), .HazA(haz_a16), .HazB(haz_b16), .PendCount(pc16)
    );

    int   checks = 0;
    int   errors = 0;
    int   step   = 0;
    vec_t exp_q[$];
    vec_t vecs[$];

    function automatic vec_t mk(bit sel, bit rst, bit regwr, int rw, logic [31:0] busw,
                                bit iv, int dst, int ra, int rb, logic [31:0] ea,
                                logic [31:0] eb, bit ha, bit hb, int pc);
        vec_t v;
        v.sel = sel;  v.rst = rst;  v.regwr = regwr;  v.rw = 5'(rw);  v.busw = busw;
        v.iv = iv;    v.dst = 5'(dst); v.ra = 5'(ra);  v.rb = 5'(rb);
        v.exp_a = ea; v.exp_b = eb; v.exp_ha = ha; v.exp_hb = hb; v.exp_pc = pc;
        v.tag = 0;
        return v;
    endfunction

    task automatic cmp(input string name, input int tag, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL step%0d %s: got %h expected %h", tag, name, act, expv);
        end
    endtask

    task automatic idleAll();
        rst32 = 0; regwr32 = 0; iv32 = 0; ra32 = 0; rb32 = 0; rw32 = 0; dst32 = 0; busw32 = 0;
        rst16 = 0; regwr16 = 0; iv16 = 0; ra16 = 0; rb16 = 0; rw16 = 0; dst16 = 0; busw16 = 0;
    endtask

    task automatic resetDut(input bit sel);
        @(negedge Clk);
        idleAll();
        if (sel) rst16 = 1; else rst32 = 1;
        @(negedge Clk);
        idleAll();
    endtask

    // Drives one cycle of inputs at the falling edge and queues what the outputs must show.
    task automatic applyStimulus(input vec_t v);
        @(negedge Clk);
        idleAll();
        if (v.sel) begin
            rst16 = v.rst; regwr16 = v.regwr; rw16 = v.rw[2:0]; busw16 = v.busw[15:0];
            iv16 = v.iv; dst16 = v.dst[2:0]; ra16 = v.ra[2:0]; rb16 = v.rb[2:0];
        end else begin
            rst32 = v.rst; regwr32 = v.regwr; rw32 = v.rw; busw32 = v.busw;
            iv32 = v.iv; dst32 = v.dst; ra32 = v.ra; rb32 = v.rb;
        end
        v.tag = step++;
        exp_q.push_back(v);
    endtask

    task automatic checkOutput();
        vec_t e;
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        checks--;
        e = exp_q.pop_front();
        if (e.sel) begin
            cmp("BusA", e.tag, 32'(bus_a16), e.exp_a);
            cmp("BusB", e.tag, 32'(bus_b16), e.exp_b);
            cmp("HazA", e.tag, 32'(haz_a16), 32'(e.exp_ha));
            cmp("HazB", e.tag, 32'(haz_b16), 32'(e.exp_hb));
            cmp("PendCount", e.tag, 32'(pc16), 32'(e.exp_pc));
        end else begin
            cmp("BusA", e.tag, bus_a32, e.exp_a);
            cmp("BusB", e.tag, bus_b32, e.exp_b);
            cmp("HazA", e.tag, 32'(haz_a32), 32'(e.exp_ha));
            cmp("HazB", e.tag, 32'(haz_b32), 32'(e.exp_hb));
            cmp("PendCount", e.tag, 32'(pc32), 32'(e.exp_pc));
        end
    endtask

    logic [15:0] m_mem [8];
    logic [7:0]  m_pend;

    initial begin
        vec_t v;
        idleAll();
        resetDut(0);

        //            sel rst wr rw busw           iv dst ra rb  expA           expB           hA hB pc
        vecs.push_back(mk(0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 32'hDEADBEEF, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 5, 0, 32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 7, 32'h12345678, 0, 0, 7, 5, 32'h12345678, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 7, 7, 32'h12345678, 32'h12345678, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 7, 32'h0,        32'h12345678, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 3, 3, 3, 32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 3, 7, 32'h0,        32'h12345678, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 3, 32'h55,       0, 0, 3, 3, 32'h55,       32'h55,       0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 3, 0, 32'h55,       32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 9, 9, 0, 32'h0,        32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 9, 32'hA,        1, 9, 9, 9, 32'hA,        32'hA,        0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 9, 4, 32'hA,        32'h0,        1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 9, 32'hB,        1, 4, 9, 4, 32'hB,        32'h0,        0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 4, 9, 32'h0,        32'hB,        1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 4, 4, 0, 32'h0,        32'h0,        1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 4, 0, 32'h0,        32'h0,        1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 6, 32'h66,       1, 6, 6, 0, 32'h66,       32'h0,        0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 6, 4, 32'h66,       32'h0,        1, 1, 2));
        vecs.push_back(mk(0, 0, 1, 4, 32'h44,       0, 0, 4, 6, 32'h44,       32'h66,       0, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 4, 6, 32'h44,       32'h66,       0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 8, 32'h88,       1, 6, 8, 6, 32'h88,       32'h66,       0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 8, 6, 32'h0,        32'h0,        0, 0, 0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput();
        end

        // Fill every register of the small instance, then write back r0.
        resetDut(1);
        for (int r = 0; r < 8; r++) begin
            applyStimulus(mk(1, 0, 0, 0, 32'h0, 1, r, r, 0, 32'h0, 32'h0, 0, r > 0, r));
            checkOutput();
        end
        applyStimulus(mk(1, 0, 0, 0, 32'h0,  0, 0, 0, 7, 32'h0,  32'h0,  1, 1, 8));
        checkOutput();
        applyStimulus(mk(1, 0, 1, 0, 32'hFF, 0, 0, 0, 0, 32'hFF, 32'hFF, 0, 0, 8));
        checkOutput();
        applyStimulus(mk(1, 0, 0, 0, 32'h0,  0, 0, 0, 1, 32'hFF, 32'h0,  0, 1, 7));
        checkOutput();

        // Random traffic against an independent reference model.
        resetDut(1);
        for (int k = 0; k < 8; k++) m_mem[k] = '0;
        m_pend = '0;
        for (int n = 0; n < 10000; n++) begin
            v = mk(1, $urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
                   int'($urandom_range(0, 7)), 32'($urandom_range(0, 65535)),
                   $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   32'h0, 32'h0, 0, 0, 0);
            v.exp_a  = (v.regwr && v.rw == v.ra) ? v.busw : 32'(m_mem[v.ra[2:0]]);
            v.exp_b  = (v.regwr && v.rw == v.rb) ? v.busw : 32'(m_mem[v.rb[2:0]]);
            v.exp_ha = m_pend[v.ra[2:0]] && !(v.regwr && v.rw == v.ra);
            v.exp_hb = m_pend[v.rb[2:0]] && !(v.regwr && v.rw == v.rb);
            v.exp_pc = $countones(m_pend);
            applyStimulus(v);
            checkOutput();
            if (v.rst) begin
                for (int k = 0; k < 8; k++) m_mem[k] = '0;
                m_pend = '0;
            end else begin
                if (v.regwr) begin
                    m_mem[v.rw[2:0]]  = v.busw[15:0];
                    m_pend[v.rw[2:0]] = 1'b0;
                end
                if (v.iv) m_pend[v.dst[2:0]] = 1'b1;
            end
        end

        @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
